// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered ALU with start/busy/done handshake and shift-add multiply
module seq_alu #(
  parameter int WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;

  // WB is the writeback cycle shared by single-step ops and the multiplier,
  // so both paths publish F/status/done from one place.
  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_WB
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           fs_q, fs_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [1:0]           vc_q, vc_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     f_q, f_d;
  logic [3:0]           status_q, status_d;

  logic [WIDTH-1:0]     ac, bc;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   addend;
  logic [WIDTH-1:0]     exec_res;
  logic                 exec_v, exec_c;
  logic [WIDTH-1:0]     wb_res;
  logic                 wb_is_mul, wb_v, wb_c;

  assign ac  = fs_q[1] ? ~a_q : a_q;
  assign bc  = fs_q[0] ? ~b_q : b_q;
  assign sum = {1'b0, ac} + {1'b0, bc} + {{WIDTH{1'b0}}, fs_q[0]};

  // Partial product for the multiplier bit selected by cnt (LSB first).
  assign addend = bc[cnt_q] ? ({{WIDTH{1'b0}}, ac} << cnt_q) : '0;

  assign wb_res    = acc_q[WIDTH-1:0];
  assign wb_is_mul = (fs_q[4:2] == OP_MUL);
  assign wb_c      = wb_is_mul ? |acc_q[2*WIDTH-1:WIDTH] : vc_q[0];
  assign wb_v      = wb_is_mul ? 1'b0 : vc_q[1];

  // Single-step result and add flags from the latched operands.
  always_comb begin
    exec_res = '0;
    exec_v   = 1'b0;
    exec_c   = 1'b0;
    case (fs_q[4:2])
      OP_AND: exec_res = ac & bc;
      OP_OR:  exec_res = ac | bc;
      OP_ADD: begin
        exec_res = sum[WIDTH-1:0];
        exec_c   = sum[WIDTH];
        exec_v   = ~(ac[WIDTH-1] ^ bc[WIDTH-1]) & (ac[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_XOR: exec_res = ac ^ bc;
      OP_SHL: exec_res = a_q << b_q[SHW-1:0];
      OP_SHR: exec_res = a_q >> b_q[SHW-1:0];
      default: exec_res = '0;
    endcase
  end

  // Next-state and datapath updates for the handshake FSM.
  always_comb begin
    state_d  = state_q;
    fs_d     = fs_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    vc_d     = vc_q;
    done_d   = 1'b0;
    f_d      = f_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          fs_d    = FS;
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (FS[4:2] == OP_MUL) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC: begin
        acc_d   = {{WIDTH{1'b0}}, exec_res};
        vc_d    = {exec_v, exec_c};
        state_d = S_WB;
      end
      S_MUL: begin
        acc_d = acc_q + addend;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH - 1)) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        f_d      = wb_res;
        status_d = {wb_v, wb_c, (wb_res == '0), wb_res[WIDTH-1]};
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any op in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fs_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      vc_q     <= '0;
      done_q   <= 1'b0;
      f_q      <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      fs_q     <= fs_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      vc_q     <= vc_d;
      done_q   <= done_d;
      f_q      <= f_d;
      status_q <= status_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign F      = f_q;
  assign status = status_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu (64-bit and 16-bit instances)
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  FS;
  logic [63:0] A, B;
  logic        busy, done;
  logic [63:0] F;
  logic [3:0]  status;

  logic        s_start;
  logic [4:0]  s_fs;
  logic [15:0] s_a, s_b;
  logic        s_busy, s_done;
  logic [15:0] s_f;
  logic [3:0]  s_st;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  seq_alu #(.WIDTH(64)) dut (
    .clock(clk), .reset(rst), .start(start), .FS(FS), .A(A), .B(B),
    .busy(busy), .done(done), .F(F), .status(status)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .clock(clk), .reset(rst), .start(s_start), .FS(s_fs), .A(s_a), .B(s_b),
    .busy(s_busy), .done(s_done), .F(s_f), .status(s_st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result {F, V, C, Z, N} for a w-bit ALU, from plain arithmetic.
  function automatic logic [67:0] alu_ref(input int w, input logic [4:0] fs,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] mask, ac, bc, am, full;
    logic [63:0]  f;
    logic         v, c;
    int           sh;
    mask = (128'd1 << w) - 128'd1;
    am   = {64'd0, a} & mask;
    ac   = {64'd0, (fs[1] ? ~a : a)} & mask;
    bc   = {64'd0, (fs[0] ? ~b : b)} & mask;
    sh   = int'(b[5:0]) % w;
    v    = 1'b0;
    c    = 1'b0;
    case (fs[4:2])
      3'd0: full = ac & bc;
      3'd1: full = ac | bc;
      3'd2: begin
        full = ac + bc + {127'd0, fs[0]};
        c    = full[w];
      end
      3'd3: full = ac ^ bc;
      3'd4: full = (am << sh) & mask;
      3'd5: full = am >> sh;
      3'd6: begin
        full = ac * bc;
        c    = (full >> w) != 128'd0;
      end
      default: full = 128'd0;
    endcase
    f = full[63:0] & mask[63:0];
    if (fs[4:2] == 3'd2) v = (ac[w-1] == bc[w-1]) && (ac[w-1] != f[w-1]);
    return {f, v, c, (f == 64'd0), f[w-1]};
  endfunction

  // Transaction model: remembers the accepted op and how many edges remain.
  int          m_left;
  logic        m_done;
  logic [63:0] m_f;
  logic [3:0]  m_st;
  logic [67:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_f    <= '0;
      m_st   <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_pend <= alu_ref(64, FS, A, B);
          m_left <= (FS[4:2] == 3'b110) ? 65 : 2;
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_f    <= m_pend[67:4];
          m_st   <= m_pend[3:0];
        end
      end
    end
  end

  // Every-cycle comparison of the 64-bit DUT against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if ({busy, done, F, status} !== {(m_left != 0), m_done, m_f, m_st}) begin
        errors++;
        $display("FAIL model_cmp t=%0t: busy=%b done=%b F=%h status=%b expected busy=%b done=%b F=%h status=%b",
                 $time, busy, done, F, status, (m_left != 0), m_done, m_f, m_st);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] fs, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] ef, input logic [3:0] est,
                        input int elat, input int inject, input bit b2b);
    int lat;
    bit seen;
    if (!b2b) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1; FS = fs; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; FS = 5'($urandom); A = {$urandom, $urandom}; B = {$urandom, $urandom};
    lat = 0;
    seen = 0;
    while (!seen && lat < 200) begin
      if (lat == inject) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
      if (done) seen = 1;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
    chk({name, "_latency"}, 64'(lat), 64'(elat));
    chk({name, "_F"}, F, ef);
    chk({name, "_status"}, 64'(status), 64'(est));
  endtask

  initial begin
    int lat;
    bit seen;
    logic [67:0] r16;
    rst = 1'b1; start = 1'b0; FS = '0; A = '0; B = '0;
    s_start = 1'b0; s_fs = '0; s_a = '0; s_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_F", F, 64'd0);
    chk("reset_status", 64'(status), 64'd0);
    chk("reset16_F", 64'(s_f), 64'd0);
    #2 rst = 1'b0;
    cmp_en = 1;

    run_op("sub_5_3", 5'b01001, 64'd5, 64'd3, 64'd2, 4'b0100, 2, -1, 0);
    run_op("sub_3_5", 5'b01001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, 2, -1, 0);
    run_op("add_ovf", 5'b01000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           64'h8000_0000_0000_0000, 4'b1001, 2, -1, 1);
    run_op("mul_small", 5'b11000, 64'd12345, 64'd678, 64'd8369910, 4'b0000, 65, 30, 0);
    run_op("mul_ovf", 5'b11000, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 4'b0110, 65, -1, 0);
    run_op("shr_b2b", 5'b10100, 64'h80, 64'd7, 64'd1, 4'b0000, 2, -1, 1);
    run_op("shl_zero", 5'b10000, 64'hDEAD, 64'd64, 64'hDEAD, 4'b0000, 2, 1, 0);
    run_op("or_inva", 5'b00110, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001, 2, -1, 1);
    run_op("op_zero", 5'b11100, 64'd5, 64'd3, 64'd0, 4'b0010, 2, -1, 0);
    run_op("xor", 5'b01100, 64'hFF, 64'h0F, 64'hF0, 4'b0000, 2, -1, 0);

    // Abort a multiply with an asynchronous reset part-way through.
    @(posedge clk);
    #1;
    start = 1'b1; FS = 5'b11000; A = 64'd999; B = 64'd777;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_F", F, 64'd0);
    chk("abort_status", 64'(status), 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    run_op("and_after_rst", 5'b00000, 64'hF0, 64'h3C, 64'h30, 4'b0000, 2, -1, 0);

    // 16-bit instance: 255*255 after WIDTH+1 edges.
    @(posedge clk);
    #1;
    s_start = 1'b1; s_fs = 5'b11000; s_a = 16'd255; s_b = 16'd255;
    r16 = alu_ref(16, 5'b11000, 64'd255, 64'd255);
    @(posedge clk);
    #1;
    s_start = 1'b0; s_a = 16'h1234; s_b = 16'h4321;
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (s_done) seen = 1;
    end
    chk("mul16_done_seen", 64'(seen), 64'd1);
    chk("mul16_latency", 64'(lat), 64'd17);
    chk("mul16_F", 64'(s_f), 64'hFE01);
    chk("mul16_status", 64'(s_st), 64'(4'b0001));
    chk("mul16_F_model", 64'(s_f), r16[67:4]);

    repeat (3) @(posedge clk);
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
